// File: rtl/nist_mon_pkg.sv
// Shared state encodings and fail-window counter constants for the NIST health monitor.
package nist_mon_pkg;

   typedef enum logic [1:0] {
      ST_WARMUP = 2'd0,
      ST_RUN    = 2'd1,
      ST_ALARM  = 2'd2
   } mon_state_e;

   localparam int FAIL_WIN_W = 8;
   localparam logic [FAIL_WIN_W-1:0] FAIL_WIN_MAX = 8'hFF;
   localparam logic [FAIL_WIN_W-1:0] FAIL_WIN_ONE = 8'h01;

   function automatic logic [FAIL_WIN_W-1:0] fail_win_sat_inc(input logic [FAIL_WIN_W-1:0] v);
      logic [FAIL_WIN_W-1:0] r;
      if (v == FAIL_WIN_MAX) begin
         r = FAIL_WIN_MAX;
      end else begin
         r = v + FAIL_WIN_ONE;
      end
      return r;
   endfunction

endpackage

// File: rtl/nist_fail_track.sv
// Per-test tracker: rising-edge event detect, per-window sticky fail flag and
// saturating count of consecutive failing windows.
module nist_fail_track
   import nist_mon_pkg::*;
#(
   parameter int FAIL_LIMIT = 3
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic hold_i,
   input  logic win_end_i,
   input  logic err_i,
   output logic wfail_o,
   output logic next_consec_hit_o
);

   localparam int CW = $clog2(FAIL_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(FAIL_LIMIT);
   localparam logic [CW-1:0] ONE   = CW'(1'b1);

   logic          err_q;
   logic          win_fail_q, win_fail_d;
   logic [CW-1:0] consec_q, consec_d, consec_nxt_s;
   logic          event_s, wfail_s;

   assign event_s = err_i & ~err_q;

   // An event in the window's last cycle still belongs to that window.
   always_comb begin
      wfail_s      = 1'b0;
      consec_nxt_s = '0;
      win_fail_d   = win_fail_q;
      consec_d     = consec_q;
      if (hold_i) begin
         wfail_s = 1'b0;
      end else begin
         wfail_s = win_fail_q | event_s;
      end
      if (!wfail_s) begin
         consec_nxt_s = '0;
      end else if (consec_q >= LIMIT) begin
         consec_nxt_s = LIMIT;
      end else begin
         consec_nxt_s = consec_q + ONE;
      end
      if (clr_i || hold_i) begin
         win_fail_d = 1'b0;
         consec_d   = '0;
      end else if (win_end_i) begin
         win_fail_d = 1'b0;
         consec_d   = consec_nxt_s;
      end else begin
         win_fail_d = wfail_s;
         consec_d   = consec_q;
      end
   end

   assign wfail_o           = wfail_s;
   assign next_consec_hit_o = (consec_nxt_s == LIMIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q      <= 1'b0;
         win_fail_q <= 1'b0;
         consec_q   <= '0;
      end else begin
         err_q      <= err_i;
         win_fail_q <= win_fail_d;
         consec_q   <= consec_d;
      end
   end

endmodule

// File: rtl/nist_health_monitor.sv
// Windowed health monitor over the NIST test error flags: WARMUP/RUN/ALARM FSM,
// registered healthy qualifier, sticky alarm with per-test fail mask.
module nist_health_monitor
   import nist_mon_pkg::*;
#(
   parameter int N_TESTS    = 4,
   parameter int WIN_LOG2   = 10,
   parameter int WARMUP_WIN = 2,
   parameter int FAIL_LIMIT = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_TESTS-1:0]    error_in,
   input  logic                  clr_alarm,
   output logic                  rnd_ok,
   output logic                  alarm,
   output logic [N_TESTS-1:0]    fail_mask,
   output logic [FAIL_WIN_W-1:0] fail_windows,
   output logic                  win_end
);

   localparam logic [WIN_LOG2-1:0] WIN_ONE   = WIN_LOG2'(1'b1);
   localparam logic [3:0]          WARM_LAST = 4'(WARMUP_WIN - 1);
   localparam logic [3:0]          WARM_ONE  = 4'd1;

   mon_state_e            state_q, state_d;
   logic [WIN_LOG2-1:0]   win_cnt_q;
   logic [3:0]            warm_cnt_q, warm_cnt_d;
   logic [N_TESTS-1:0]    fail_mask_q, fail_mask_d;
   logic [FAIL_WIN_W-1:0] fail_win_q, fail_win_d;
   logic [N_TESTS-1:0]    wfail_s, hit_s;
   logic                  rnd_ok_q, alarm_q, hold_s;

   assign win_end = &win_cnt_q;
   assign hold_s  = (state_q != ST_RUN);

   for (genvar gi = 0; gi < N_TESTS; gi++) begin : g_track
      nist_fail_track #(
         .FAIL_LIMIT(FAIL_LIMIT)
      ) u_track (
         .clk              (clk),
         .rst              (rst),
         .clr_i            (clr_alarm),
         .hold_i           (hold_s),
         .win_end_i        (win_end),
         .err_i            (error_in[gi]),
         .wfail_o          (wfail_s[gi]),
         .next_consec_hit_o(hit_s[gi])
      );
   end

   // Clear wins over every transition; the window counter is never restarted.
   always_comb begin
      state_d     = state_q;
      warm_cnt_d  = warm_cnt_q;
      fail_mask_d = fail_mask_q;
      fail_win_d  = fail_win_q;
      if (clr_alarm) begin
         state_d     = ST_WARMUP;
         warm_cnt_d  = '0;
         fail_mask_d = '0;
         fail_win_d  = '0;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               if (!win_end) begin
                  warm_cnt_d = warm_cnt_q;
               end else if (warm_cnt_q == WARM_LAST) begin
                  state_d    = ST_RUN;
                  warm_cnt_d = '0;
               end else begin
                  warm_cnt_d = warm_cnt_q + WARM_ONE;
               end
            end
            ST_RUN: begin
               if (win_end) begin
                  if (|wfail_s) begin
                     fail_win_d = fail_win_sat_inc(fail_win_q);
                  end else begin
                     fail_win_d = fail_win_q;
                  end
                  if (|hit_s) begin
                     state_d     = ST_ALARM;
                     fail_mask_d = hit_s;
                  end else begin
                     state_d = ST_RUN;
                  end
               end else begin
                  state_d = ST_RUN;
               end
            end
            ST_ALARM: begin
               state_d = ST_ALARM;
            end
            default: begin
               state_d    = ST_WARMUP;
               warm_cnt_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_WARMUP;
         win_cnt_q   <= '0;
         warm_cnt_q  <= '0;
         fail_mask_q <= '0;
         fail_win_q  <= '0;
         rnd_ok_q    <= 1'b0;
         alarm_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         win_cnt_q   <= win_cnt_q + WIN_ONE;
         warm_cnt_q  <= warm_cnt_d;
         fail_mask_q <= fail_mask_d;
         fail_win_q  <= fail_win_d;
         rnd_ok_q    <= (state_d == ST_RUN);
         alarm_q     <= (state_d == ST_ALARM);
      end
   end

   assign rnd_ok       = rnd_ok_q;
   assign alarm        = alarm_q;
   assign fail_mask    = fail_mask_q;
   assign fail_windows = fail_win_q;

endmodule

// File: tb/tb_nist_health_monitor.sv
// Scoreboard bench for nist_health_monitor: a cycle model pushes expected outputs
// as each input cycle is driven; they are popped and compared after the edge.
module tb_nist_health_monitor;

   localparam int NT = 4;
   localparam int M_WARMUP = 0;
   localparam int M_RUN    = 1;
   localparam int M_ALARM  = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [NT-1:0] error_in = '0;
   logic          clr_alarm = 1'b0;
   logic          rnd_ok, alarm, win_end;
   logic [NT-1:0] fail_mask;
   logic [7:0]    fail_windows;

   int n_checks = 0;
   int n_pass   = 0;

   logic [14:0] exp_q[$];

   logic [3:0] m_errq, m_wf, m_mask;
   int         m_cons[NT];
   int         m_win, m_warm, m_state, m_fw;

   nist_health_monitor #(
      .N_TESTS(NT), .WIN_LOG2(4), .WARMUP_WIN(2), .FAIL_LIMIT(3)
   ) dut (
      .clk(clk), .rst(rst), .error_in(error_in), .clr_alarm(clr_alarm),
      .rnd_ok(rnd_ok), .alarm(alarm), .fail_mask(fail_mask),
      .fail_windows(fail_windows), .win_end(win_end)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic model_reset();
      m_errq = '0; m_wf = '0; m_mask = '0;
      for (int i = 0; i < NT; i++) m_cons[i] = 0;
      m_win = 0; m_warm = 0; m_state = M_WARMUP; m_fw = 0;
   endtask

   task automatic model_step(input logic [3:0] e, input logic c);
      logic [3:0] ev, wfail, hit;
      bit         we;
      int         nc;
      ev = e & ~m_errq;
      m_errq = e;
      we = (m_win == 15);
      hit = '0;
      if (c) begin
         m_state = M_WARMUP; m_warm = 0; m_mask = '0; m_fw = 0; m_wf = '0;
         for (int i = 0; i < NT; i++) m_cons[i] = 0;
      end else if (m_state == M_RUN) begin
         wfail = m_wf | ev;
         if (we) begin
            if (wfail != 4'b0) m_fw = (m_fw == 255) ? 255 : m_fw + 1;
            for (int i = 0; i < NT; i++) begin
               nc = wfail[i] ? ((m_cons[i] + 1 > 3) ? 3 : m_cons[i] + 1) : 0;
               hit[i] = (nc == 3);
               m_cons[i] = nc;
            end
            m_wf = '0;
            if (hit != 4'b0) begin
               m_state = M_ALARM;
               m_mask  = hit;
            end
         end else begin
            m_wf = wfail;
         end
      end else begin
         m_wf = '0;
         for (int i = 0; i < NT; i++) m_cons[i] = 0;
         if (m_state == M_WARMUP && we) begin
            m_warm++;
            if (m_warm == 2) begin
               m_state = M_RUN;
               m_warm  = 0;
            end
         end
      end
      m_win = (m_win + 1) % 16;
   endtask

   task automatic tick(input logic [3:0] e, input logic c);
      logic [14:0] obs;
      error_in  = e;
      clr_alarm = c;
      model_step(e, c);
      exp_q.push_back({m_state == M_RUN, m_state == M_ALARM, m_mask, 8'(m_fw), m_win == 15});
      @(posedge clk);
      #1;
      obs = {rnd_ok, alarm, fail_mask, fail_windows, win_end};
      chk("cycle_outputs", 32'(obs), 32'(exp_q.pop_front()));
   endtask

   task automatic idle_to(input int pos);
      for (int k = 0; k < 16 && m_win != pos; k++) tick(4'b0, 1'b0);
   endtask

   // Drive e at window position pos, then run to just past that window's end edge.
   task automatic pulse_window(input logic [3:0] e, input int pos);
      idle_to(pos);
      tick(e, 1'b0);
      if (pos != 15) begin
         idle_to(15);
         tick(4'b0, 1'b0);
      end
   endtask

   task automatic wait_run(input string tag);
      int n_we = 0;
      bit ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
         tick(4'b0, 1'b0);
         if (rnd_ok) ok = 1'b1;
         else if (win_end) n_we++;
      end
      chk({tag, "_reached_run"}, 32'(ok), 32'd1);
      chk({tag, "_win_ends"}, 32'(n_we), 32'd2);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_outputs", 32'({rnd_ok, alarm, fail_mask, fail_windows, win_end}), 32'd0);
      rst = 1'b0;
      chk("c0_rnd_ok", 32'(rnd_ok), 32'd0);
      for (int c = 1; c <= 48; c++) begin
         tick(4'b0, 1'b0);
         chk("warm_rnd_ok", 32'(rnd_ok), 32'(c >= 32));
         chk("warm_win_end", 32'(win_end), 32'((c % 16) == 15));
         chk("warm_alarm", 32'(alarm), 32'd0);
      end

      // Three consecutive failing windows on test 2.
      pulse_window(4'b0100, 5);
      pulse_window(4'b0100, 5);
      chk("two_win_no_alarm", 32'(alarm), 32'd0);
      pulse_window(4'b0100, 5);
      chk("alarm_set", 32'(alarm), 32'd1);
      chk("alarm_mask", 32'(fail_mask), 32'h4);
      chk("alarm_fw", 32'(fail_windows), 32'd3);
      chk("alarm_rnd_ok", 32'(rnd_ok), 32'd0);
      pulse_window(4'b0001, 2);
      chk("alarm_sticky_fw", 32'(fail_windows), 32'd3);

      tick(4'b0, 1'b1);
      chk("clr_alarm", 32'(alarm), 32'd0);
      chk("clr_mask", 32'(fail_mask), 32'd0);
      chk("clr_fw", 32'(fail_windows), 32'd0);
      wait_run("clr");

      // Gap window resets the consecutive count.
      pulse_window(4'b0001, 3);
      pulse_window(4'b0001, 3);
      pulse_window(4'b0000, 3);
      pulse_window(4'b0001, 3);
      chk("gap_no_alarm", 32'(alarm), 32'd0);
      chk("gap_fw", 32'(fail_windows), 32'd3);

      tick(4'b0, 1'b1);
      wait_run("clr2");
      for (int k = 0; k < 40; k++) tick(4'b0010, 1'b0);
      idle_to(15);
      tick(4'b0, 1'b0);
      pulse_window(4'b0000, 0);
      chk("held_fw", 32'(fail_windows), 32'd1);
      chk("held_no_alarm", 32'(alarm), 32'd0);

      pulse_window(4'b1000, 15);
      chk("last_cycle_fw", 32'(fail_windows), 32'd2);

      // Asynchronous reset mid-RUN with an error held across release.
      pulse_window(4'b0001, 4);
      error_in = 4'b0001;
      #3 rst = 1'b1;
      #1;
      chk("arst_outputs", 32'({rnd_ok, alarm, fail_mask, fail_windows, win_end}), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      wait_run("arst");
      chk("arst_fw", 32'(fail_windows), 32'd0);
      pulse_window(4'b0001, 7);
      chk("post_arst_fw", 32'(fail_windows), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
